// File: rtl/inert_seq.sv
// -----------------------------------------------------------------------------
// inert_seq : IMU command sequencer in front of a 16-bit SPI master.
//   After reset it waits 2**INIT_W cycles for the IMU to settle, then writes
//   four config registers. After that, each data-ready interrupt (INT) starts
//   a read set: pitch-rate L/H and Z-accel L/H. The assembled 16-bit pair is
//   presented on ptch_rt/AZ together with a one-cycle vld strobe.
//
// Optional feature macro: INERT_SETCNT_EN adds rd_cnt, a wrapping 8-bit count
// of completed read sets (+1 per vld).
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   INT      in   IMU data-ready, asynchronous (double-flopped here)
//   done     in   SPI master done level; completion = its rising edge
//   rd_data  in   SPI read data; only [7:0] carries register contents
//   wrt      out  one-cycle pulse starting an SPI transfer
//   cmd      out  SPI command word, held until the next transfer
//   ptch_rt  out  pitch rate {H,L}, updated only with vld
//   AZ       out  Z acceleration {H,L}, updated only with vld
//   vld      out  one-cycle strobe: ptch_rt/AZ hold a new coherent pair
//   rd_cnt   out  (INERT_SETCNT_EN only) completed read-set count
// -----------------------------------------------------------------------------
module inert_seq #(
    parameter int unsigned INIT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        vld
`ifdef INERT_SETCNT_EN
    ,
    output logic [7:0]  rd_cnt
`endif
);

    typedef enum logic [2:0] {
        INIT, CFG, CFGW, IDLE, RD, RDW, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [INIT_W-1:0] settle_q, settle_d;
    logic [2:0][7:0]   hold_q, hold_d;
    logic              int_ff1_q, int_ff2_q;
    logic              done_q;
    logic              wrt_q, wrt_d;
    logic [15:0]       cmd_q, cmd_d;
    logic [15:0]       ptch_q, ptch_d;
    logic [15:0]       az_q, az_d;
    logic              vld_q, vld_d;
    logic              done_rise_c;

    // Upper read byte carries no register contents.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:8];

    // Config write words, issued in order.
    function automatic logic [15:0] cfg_word(input logic [1:0] i);
        case (i)
            2'd0:    cfg_word = 16'h0D02;
            2'd1:    cfg_word = 16'h1053;
            2'd2:    cfg_word = 16'h1150;
            default: cfg_word = 16'h1460;
        endcase
    endfunction

    // Read commands: pitch L, pitch H, AZ L, AZ H.
    function automatic logic [15:0] rd_word(input logic [1:0] i);
        case (i)
            2'd0:    rd_word = 16'hA200;
            2'd1:    rd_word = 16'hA300;
            2'd2:    rd_word = 16'hAC00;
            default: rd_word = 16'hAD00;
        endcase
    endfunction

    // Completion is the rising edge of done; the level is high while idle.
    assign done_rise_c = done & ~done_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        hold_d   = hold_q;
        ptch_d   = ptch_q;
        az_d     = az_q;
        vld_d    = 1'b0;
        wrt_d    = 1'b0;
        cmd_d    = cmd_q;

        unique case (state_q)
            INIT: begin
                if (settle_q == '1) begin
                    state_d = CFG;
                    idx_d   = 2'd0;
                end else begin
                    settle_d = settle_q + INIT_W'(1);
                end
            end
            CFG:  state_d = CFGW;
            CFGW: begin
                if (done_rise_c) begin
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = CFG;
                    end
                end
            end
            IDLE: begin
                if (int_ff2_q) begin
                    state_d = RD;
                    idx_d   = 2'd0;
                end
            end
            RD:   state_d = RDW;
            RDW: begin
                if (done_rise_c) begin
                    if (idx_q == 2'd3) begin
                        // Last byte goes straight to AZ so the pair updates together.
                        ptch_d  = {hold_q[1], hold_q[0]};
                        az_d    = {rd_data[7:0], hold_q[2]};
                        vld_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        hold_d[idx_q] = rd_data[7:0];
                        idx_d         = idx_q + 2'd1;
                        state_d       = RD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = INIT;
        endcase

        // wrt/cmd are registered on entry so the pulse coincides with CFG/RD.
        if (state_d == CFG) begin
            wrt_d = 1'b1;
            cmd_d = cfg_word(idx_d);
        end else if (state_d == RD) begin
            wrt_d = 1'b1;
            cmd_d = rd_word(idx_d);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            idx_q     <= 2'd0;
            settle_q  <= '0;
            hold_q    <= '0;
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
            done_q    <= 1'b1;
            wrt_q     <= 1'b0;
            cmd_q     <= 16'h0000;
            ptch_q    <= 16'h0000;
            az_q      <= 16'h0000;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            hold_q    <= hold_d;
            int_ff1_q <= INT;
            int_ff2_q <= int_ff1_q;
            done_q    <= done;
            wrt_q     <= wrt_d;
            cmd_q     <= cmd_d;
            ptch_q    <= ptch_d;
            az_q      <= az_d;
            vld_q     <= vld_d;
        end
    end

`ifdef INERT_SETCNT_EN
    logic [7:0] rd_cnt_q;

    // Completed read-set counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= 8'h00;
        end else if (vld_d) begin
            rd_cnt_q <= rd_cnt_q + 8'd1;
        end
    end

    assign rd_cnt = rd_cnt_q;
`endif

    assign wrt     = wrt_q;
    assign cmd     = cmd_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;
    assign vld     = vld_q;

endmodule

// File: tb/tb_inert_seq.sv
// -----------------------------------------------------------------------------
// tb_inert_seq : self-checking bench for inert_seq with a behavioural SPI
// master + IMU register model. Directed vectors with hand-computed results.
// -----------------------------------------------------------------------------
module tb_inert_seq;

    localparam int unsigned INIT_W  = 4;
    localparam int unsigned SPI_LAT = 6;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        INT     = 1'b0;
    logic        done    = 1'b1;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;
    logic        vld;
`ifdef INERT_SETCNT_EN
    logic [7:0]  rd_cnt;
`endif

    inert_seq #(.INIT_W(INIT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (INT),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .vld     (vld)
`ifdef INERT_SETCNT_EN
        ,
        .rd_cnt  (rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- SPI master + IMU slave model ----------------
    int          spi_cnt = 0;
    logic [15:0] spi_cmd = 16'h0000;
    logic [15:0] pitch_v = 16'h0000;
    logic [15:0] az_v    = 16'h0000;

    function automatic logic [7:0] imu_rd(input logic [6:0] a,
                                          input logic [15:0] p,
                                          input logic [15:0] z);
        case (a)
            7'h22:   imu_rd = p[7:0];
            7'h23:   imu_rd = p[15:8];
            7'h2C:   imu_rd = z[7:0];
            7'h2D:   imu_rd = z[15:8];
            default: imu_rd = 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (spi_cnt != 0) begin
            spi_cnt <= spi_cnt - 1;
            if (spi_cnt == 1) begin
                done    <= 1'b1;
                rd_data <= spi_cmd[15] ? {8'hA5, imu_rd(spi_cmd[14:8], pitch_v, az_v)}
                                       : 16'h5A00;
            end
        end else if (wrt) begin
            done    <= 1'b0;
            spi_cnt <= int'(SPI_LAT);
            spi_cmd <= cmd;
        end
    end

    // ---------------- monitors ----------------
    logic [15:0] cmd_log[$];
    int          wrt_cnt   = 0;
    int          vld_cnt   = 0;
    int          proto_err = 0;
    int          stab_err  = 0;
    logic        wrt_prev  = 1'b0;
    logic        vld_prev  = 1'b0;
    logic        rst_e     = 1'b1;
    logic [15:0] p_prev    = 16'h0000;
    logic [15:0] a_prev    = 16'h0000;

    always @(posedge clk) rst_e <= rst;

    always @(negedge clk) begin
        if (wrt) begin
            cmd_log.push_back(cmd);
            wrt_cnt <= wrt_cnt + 1;
            if (!done || wrt_prev) proto_err <= proto_err + 1;
        end
        if (vld) begin
            vld_cnt <= vld_cnt + 1;
            if (vld_prev) proto_err <= proto_err + 1;
        end
        if (!rst_e && !vld && (ptch_rt != p_prev || AZ != a_prev))
            stab_err <= stab_err + 1;
        wrt_prev <= wrt;
        vld_prev <= vld;
        p_prev   <= ptch_rt;
        a_prev   <= AZ;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_vld(input string name);
        int n = 0;
        while (!vld && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_vld_seen"}, 32'(vld), 32'd1);
    endtask

    task automatic wait_wrt_cnt(input int target);
        int n = 0;
        while (wrt_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for the config sequence to finish and checks it.
    task automatic chk_cfg(input int lbase);
        logic [15:0] exp_cfg[4];
        int          n = 0;
        exp_cfg = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
        while ((cmd_log.size() < lbase + 4 || !done) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("cfg_count", 32'(cmd_log.size() - lbase), 32'd4);
        for (int i = 0; i < 4; i++)
            if (lbase + i < cmd_log.size())
                chk($sformatf("cfg_cmd%0d", i), 32'(cmd_log[lbase + i]), 32'(exp_cfg[i]));
    endtask

    // Counts negedges (including the current one) with wrt low until wrt rises.
    task automatic count_settle(output int n);
        n = 0;
        while (!wrt && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [15:0] pitch;
        logic [15:0] az;
        logic [15:0] exp_p;
        logic [15:0] exp_az;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] rd_exp[4];

    initial begin
        int n;
        int base;
        int vbase;
        int lbase;

        vecs[0] = '{16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[2] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
        vecs[3] = '{16'h00FF, 16'hFF00, 16'h00FF, 16'hFF00};
        rd_exp  = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

        // 1: reset and config sequence
        repeat (3) @(negedge clk);
        chk("rst_wrt", 32'(wrt), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_ptch", 32'(ptch_rt), 32'h0);
        chk("rst_az", 32'(AZ), 32'h0);
        chk("rst_vld", 32'(vld), 32'd0);
        rst = 1'b0;
        count_settle(n);
        chk("settle_cycles", 32'(n), 32'd16);
        chk_cfg(0);

        // 2: table-driven single read sets
        for (int v = 0; v < 4; v++) begin
            pitch_v = vecs[v].pitch;
            az_v    = vecs[v].az;
            base    = wrt_cnt;
            lbase   = cmd_log.size();
            vbase   = vld_cnt;
            INT     = 1'b1;
            n       = 0;
            do begin
                @(negedge clk);
                n++;
                INT = 1'b0;
            end while (!wrt && n < 20);
            chk($sformatf("v%0d_int_to_wrt", v), 32'(n), 32'd3);
            wait_vld($sformatf("v%0d", v));
            chk($sformatf("v%0d_ptch", v), 32'(ptch_rt), 32'(vecs[v].exp_p));
            chk($sformatf("v%0d_az", v), 32'(AZ), 32'(vecs[v].exp_az));
            @(negedge clk);
            chk($sformatf("v%0d_vld_drop", v), 32'(vld), 32'd0);
            repeat (20) @(negedge clk);
            chk($sformatf("v%0d_wrts", v), 32'(wrt_cnt - base), 32'd4);
            chk($sformatf("v%0d_vlds", v), 32'(vld_cnt - vbase), 32'd1);
            if (v == 0)
                for (int i = 0; i < 4; i++)
                    chk($sformatf("rd_cmd%0d", i), 32'(cmd_log[lbase + i]), 32'(rd_exp[i]));
        end

        // 3: INT held high -> back-to-back sets; INT still high after the 3rd
        //    set's vld yields exactly one more set.
        base    = wrt_cnt;
        vbase   = vld_cnt;
        pitch_v = 16'h1111;
        az_v    = 16'h2222;
        INT     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wait_vld($sformatf("b2b%0d", k));
            chk($sformatf("b2b%0d_ptch", k), 32'(ptch_rt), 32'(16'h1111 * (2 * k + 1)));
            chk($sformatf("b2b%0d_az", k), 32'(AZ), 32'(16'h2222 * (k + 1)));
            pitch_v = 16'(16'h1111 * (2 * k + 3));
            az_v    = 16'(16'h2222 * (k + 2));
            if (k == 2) INT = 1'b0;
        end
        repeat (60) @(negedge clk);
        chk("b2b_vlds", 32'(vld_cnt - vbase), 32'd4);
        chk("b2b_wrts", 32'(wrt_cnt - base), 32'd16);

        // 5: INT glitch during RDW must not add transfers
        pitch_v = 16'h5A5A;
        az_v    = 16'hC3C3;
        base    = wrt_cnt;
        vbase   = vld_cnt;
        INT     = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        wait_wrt_cnt(base + 2);
        repeat (2) @(negedge clk);
        INT = 1'b1;
        repeat (2) @(negedge clk);
        INT = 1'b0;
        wait_vld("glitch");
        chk("glitch_ptch", 32'(ptch_rt), 32'h5A5A);
        chk("glitch_az", 32'(AZ), 32'hC3C3);
        repeat (40) @(negedge clk);
        chk("glitch_wrts", 32'(wrt_cnt - base), 32'd4);
        chk("glitch_vlds", 32'(vld_cnt - vbase), 32'd1);

        // 4: reset during the 2nd read transfer
        pitch_v = 16'h4321;
        az_v    = 16'h8765;
        base    = wrt_cnt;
        vbase   = vld_cnt;
        INT     = 1'b1;
        @(negedge clk);
        INT = 1'b0;
        wait_wrt_cnt(base + 2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_wrt", 32'(wrt), 32'd0);
        chk("mid_rst_cmd", 32'(cmd), 32'h0);
        chk("mid_rst_ptch", 32'(ptch_rt), 32'h0);
        chk("mid_rst_az", 32'(AZ), 32'h0);
        chk("mid_rst_vld", 32'(vld), 32'd0);
        lbase = cmd_log.size();
        rst   = 1'b0;
        count_settle(n);
        chk("mid_rst_settle", 32'(n), 32'd16);
        chk_cfg(lbase);
        chk("mid_rst_vlds", 32'(vld_cnt - vbase), 32'd0);

`ifdef INERT_SETCNT_EN
        // 6: 257 read sets wrap the set counter to 1
        chk("setcnt_rst", 32'(rd_cnt), 32'h0);
        INT = 1'b1;
        n   = 0;
        for (int k = 0; k < 257 && n < 15000; ) begin
            @(negedge clk);
            n++;
            if (vld) k++;
        end
        chk("setcnt_257", 32'(rd_cnt), 32'h01);
        INT = 1'b0;
        repeat (100) @(negedge clk);
`endif

        chk("protocol_errors", 32'(proto_err), 32'd0);
        chk("stability_errors", 32'(stab_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
